// File: rtl/mul_div_unit.sv
// Radix-2 multi-cycle multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per clock, then a single sign-fix cycle.
module mul_div_unit #(
    parameter int BitWidth = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [BitWidth-1:0] a,
    input  logic [BitWidth-1:0] b,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic [BitWidth-1:0] hi,
    output logic [BitWidth-1:0] lo
);

    localparam int CntW = $clog2(BitWidth + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t                  state;
    logic [CntW-1:0]         cnt;
    logic                    is_div;
    logic                    neg_lo;
    logic                    neg_hi;
    logic [BitWidth-1:0]     addend;
    logic [BitWidth-1:0]     a_orig;
    logic [2*BitWidth-1:0]   acc;

    logic                    signed_op;
    logic [BitWidth-1:0]     mag_a;
    logic [BitWidth-1:0]     mag_b;
    logic [BitWidth:0]       mul_sum;
    logic [BitWidth:0]       div_trial;
    logic [BitWidth+1:0]     div_diff;
    logic                    div_ok;
    logic [2*BitWidth-1:0]   step_next;
    logic [2*BitWidth-1:0]   prod_fix;
    logic [BitWidth-1:0]     quo_fix;
    logic [BitWidth-1:0]     rem_fix;

    assign busy = (state != IDLE);

    assign signed_op = (op == OpMult) || (op == OpDiv);
    assign mag_a     = (signed_op && a[BitWidth-1]) ? -a : a;
    assign mag_b     = (signed_op && b[BitWidth-1]) ? -b : b;

    // acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend -> quotient} for divide; addend is the fixed operand.
    always_comb begin
        mul_sum   = {1'b0, acc[2*BitWidth-1:BitWidth]} + (acc[0] ? {1'b0, addend} : '0);
        div_trial = acc[2*BitWidth-1:BitWidth-1];
        div_diff  = {1'b0, div_trial} - {2'b00, addend};
        div_ok    = ~div_diff[BitWidth+1];
        if (is_div) begin
            step_next = {(div_ok ? div_diff[BitWidth-1:0] : div_trial[BitWidth-1:0]),
                         acc[BitWidth-2:0], div_ok};
        end else begin
            step_next = {mul_sum, acc[BitWidth-1:1]};
        end
        prod_fix = neg_lo ? -acc : acc;
        quo_fix  = neg_lo ? -acc[BitWidth-1:0] : acc[BitWidth-1:0];
        rem_fix  = neg_hi ? -acc[2*BitWidth-1:BitWidth] : acc[2*BitWidth-1:BitWidth];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            addend      <= '0;
            a_orig      <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OpMthi: hi <= a;
                            OpMtlo: lo <= a;
                            OpMult, OpMultu: begin
                                is_div      <= 1'b0;
                                addend      <= mag_a;
                                acc         <= {{BitWidth{1'b0}}, mag_b};
                                neg_lo      <= signed_op && (a[BitWidth-1] ^ b[BitWidth-1]);
                                neg_hi      <= 1'b0;
                                a_orig      <= a;
                                div_by_zero <= 1'b0;
                                cnt         <= CntW'(BitWidth);
                                state       <= RUN;
                            end
                            OpDiv, OpDivu: begin
                                is_div      <= 1'b1;
                                addend      <= mag_b;
                                acc         <= {{BitWidth{1'b0}}, mag_a};
                                neg_lo      <= signed_op && (a[BitWidth-1] ^ b[BitWidth-1]);
                                neg_hi      <= signed_op && a[BitWidth-1];
                                a_orig      <= a;
                                div_by_zero <= 1'b0;
                                cnt         <= CntW'(BitWidth);
                                state       <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc <= step_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CntW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // A zero divisor is recognised from the latched magnitude.
                    if (is_div && (addend == '0)) begin
                        lo          <= '1;
                        hi          <= a_orig;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= prod_fix[BitWidth-1:0];
                        hi <= prod_fix[2*BitWidth-1:BitWidth];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with BitWidth=32.
// Inputs change at negedge/after posedge, outputs are sampled at negedge.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.BitWidth(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present a one-cycle start request; returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles; stops on the done negedge.
    task automatic waitDone(output int busyCycles);
        busyCycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busyCycles++;
        end
        checkOutput("done_seen", {63'd0, done}, 64'd1);
    endtask

    int  cyc;
    bit  sawDone;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);

        // MULTU max*max, also checks latency
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(cyc);
        checkOutput("multu_busy_cycles", 64'(cyc), 64'd33);
        checkOutput("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        @(negedge clk);
        checkOutput("done_one_cycle", {63'd0, done}, 64'd0);

        // MULT -7*6, then MTHI in the done cycle lands after the result
        applyStimulus(3'd0, 32'hFFFFFFF9, 32'd6);
        waitDone(cyc);
        checkOutput("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
        applyStimulus(3'd4, 32'h0000ABCD, 32'd0);
        @(negedge clk);
        checkOutput("mthi_after_result", {hi, lo}, 64'h0000ABCD_FFFFFFD6);
        checkOutput("mthi_no_busy", {62'd0, busy, done}, 64'd0);

        // DIV -7/2
        applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
        waitDone(cyc);
        checkOutput("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        checkOutput("div_neg_dbz", {63'd0, div_by_zero}, 64'd0);

        // DIV most-negative / -1
        applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
        waitDone(cyc);
        checkOutput("div_overflow", {hi, lo}, 64'h00000000_80000000);
        checkOutput("div_overflow_dbz", {63'd0, div_by_zero}, 64'd0);

        // DIVU large operands
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'h80000001);
        waitDone(cyc);
        checkOutput("divu_large", {hi, lo}, 64'h7FFFFFFE_00000001);

        // DIV signed by zero
        applyStimulus(3'd2, 32'hFFFFFFF9, 32'd0);
        waitDone(cyc);
        checkOutput("div_zero_signed", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
        checkOutput("div_zero_signed_flag", {63'd0, div_by_zero}, 64'd1);

        // DIVU 100/0, MTLO keeps the flag, next mul/div start clears it
        applyStimulus(3'd3, 32'd100, 32'd0);
        waitDone(cyc);
        checkOutput("divu_zero", {hi, lo}, 64'h00000064_FFFFFFFF);
        checkOutput("divu_zero_flag", {63'd0, div_by_zero}, 64'd1);
        @(negedge clk);
        applyStimulus(3'd5, 32'd5, 32'd0);
        @(negedge clk);
        checkOutput("mtlo", {hi, lo}, 64'h00000064_00000005);
        checkOutput("mtlo_keeps_dbz", {63'd0, div_by_zero}, 64'd1);
        applyStimulus(3'd1, 32'd3, 32'd4);
        @(negedge clk);
        checkOutput("start_clears_dbz", {62'd0, busy, div_by_zero}, 64'd2);
        waitDone(cyc);
        checkOutput("multu_small", {hi, lo}, 64'd12);

        // Reset in the middle of RUN
        @(negedge clk);
        applyStimulus(3'd1, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset", {hi[30:0], lo, busy}, 64'd0);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("no_done_after_reset", {63'd0, sawDone}, 64'd0);
        checkOutput("hi_after_reset", {32'd0, hi}, 64'd0);

        // Start held while busy is ignored
        op    = 3'd1;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd5;
        b = 32'd5;
        repeat (6) @(posedge clk);
        #1 start = 1'b0;
        waitDone(cyc);
        checkOutput("busy_start_ignored", {hi, lo}, 64'd12);
        @(negedge clk);
        checkOutput("no_second_op", {63'd0, busy}, 64'd0);

        // Back-to-back start in the done cycle
        applyStimulus(3'd1, 32'd3, 32'd4);
        waitDone(cyc);
        checkOutput("b2b_first", {hi, lo}, 64'd12);
        applyStimulus(3'd1, 32'd7, 32'd8);
        @(negedge clk);
        checkOutput("b2b_accepted", {63'd0, busy}, 64'd1);
        waitDone(cyc);
        checkOutput("b2b_busy_cycles", 64'(cyc + 1), 64'd33);
        checkOutput("b2b_second", {hi, lo}, 64'd56);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
